// File: rtl/memory_controller_pkg.sv
// Shared definitions for the byte-serial memory controller: op codes, FSM states
// and the access-length helper.
package memory_controller_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  // Number of bus bytes an access occupies; unknown codes are treated as words.
  function automatic logic [2:0] op_len(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extension: sign-extends LB/LH, zero-extends LBU/LHU,
// passes words through unchanged.
module mem_load_ext
  import memory_controller_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  ext = {24'd0, raw[7:0]};
      OP_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// Serialises 1/2/4-byte loads, stores and instruction fetches onto a byte-wide
// RAM/IO bus with one-cycle read latency; store > load > fetch priority.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        lsb_load,
  input  logic [31:0] load_address,
  input  logic [5:0]  op_type_load,
  output logic        finish_load,
  output logic [31:0] data_load,
  input  logic        lsb_store,
  input  logic [31:0] store_address,
  input  logic [31:0] data_store,
  input  logic [5:0]  op_type_store,
  output logic        finish_store,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        finish_fetch,
  output logic [31:0] instruction_out
);

  mc_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [5:0]  op_q, op_d;
  logic        fetch_q, fetch_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        wr_q, wr_d;
  logic        finish_load_q, finish_load_d;
  logic        finish_store_q, finish_store_d;
  logic        finish_fetch_q, finish_fetch_d;
  logic [31:0] data_load_q, data_load_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] merged;
  logic [31:0] load_ext;
  logic [1:0]  next_byte;
  logic        store_blocked;

  assign store_blocked = (store_address[17:16] == IO_HI) && io_buffer_full;
  assign next_byte     = cnt_q[1:0] + 2'd1;

  // Captured bytes with the byte currently on mem_din folded in, so the last
  // byte reaches the outputs on the same edge it is sampled.
  always_comb begin
    merged = buf_q;
    case (cnt_q)
      3'd1:    merged[7:0]   = mem_din;
      3'd2:    merged[15:8]  = mem_din;
      3'd3:    merged[23:16] = mem_din;
      3'd4:    merged[31:24] = mem_din;
      default: merged = buf_q;
    endcase
  end

  mem_load_ext u_ext (
    .op  (op_q),
    .raw (merged),
    .ext (load_ext)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    op_d           = op_q;
    fetch_d        = fetch_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    buf_d          = buf_q;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    wr_d           = wr_q;
    finish_load_d  = finish_load_q;
    finish_store_d = finish_store_q;
    finish_fetch_d = finish_fetch_q;
    data_load_d    = data_load_q;
    instr_d        = instr_q;
    if (rdy_in) begin
      finish_load_d  = 1'b0;
      finish_store_d = 1'b0;
      finish_fetch_d = 1'b0;
      case (state_q)
        MC_IDLE: begin
          if (!roll_back) begin
            if (lsb_store) begin
              // A blocked IO store also holds back loads and fetches behind it.
              if (!store_blocked) begin
                state_d    = MC_WRITE;
                cnt_d      = 3'd0;
                len_d      = op_len(op_type_store);
                addr_d     = store_address;
                wdata_d    = data_store;
                wr_d       = 1'b1;
                mem_a_d    = store_address;
                mem_dout_d = data_store[7:0];
              end
            end else if (lsb_load || ifetch_req) begin
              state_d = MC_READ;
              cnt_d   = 3'd0;
              buf_d   = 32'd0;
              fetch_d = !lsb_load;
              addr_d  = lsb_load ? load_address : ifetch_addr;
              op_d    = lsb_load ? op_type_load : OP_LW;
              len_d   = lsb_load ? op_len(op_type_load) : 3'd4;
              mem_a_d = addr_d;
            end
          end
        end
        MC_READ: begin
          if (roll_back) begin
            state_d = MC_IDLE;
            wr_d    = 1'b0;
          end else begin
            mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
            cnt_d   = cnt_q + 3'd1;
            buf_d   = merged;
            if (cnt_q == len_q) begin
              state_d = MC_DONE;
              if (fetch_q) begin
                instr_d        = merged;
                finish_fetch_d = 1'b1;
              end else begin
                data_load_d   = load_ext;
                finish_load_d = 1'b1;
              end
            end
          end
        end
        MC_WRITE: begin
          if (cnt_q + 3'd1 == len_q) begin
            state_d        = MC_DONE;
            wr_d           = 1'b0;
            finish_store_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = addr_q + {29'd0, cnt_q} + 32'd1;
            mem_dout_d = wdata_q[{next_byte, 3'b000} +: 8];
          end
        end
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= MC_IDLE;
      cnt_q          <= 3'd0;
      len_q          <= 3'd0;
      op_q           <= 6'd0;
      fetch_q        <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      buf_q          <= 32'd0;
      mem_a_q        <= 32'd0;
      mem_dout_q     <= 8'd0;
      wr_q           <= 1'b0;
      finish_load_q  <= 1'b0;
      finish_store_q <= 1'b0;
      finish_fetch_q <= 1'b0;
      data_load_q    <= 32'd0;
      instr_q        <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      op_q           <= op_d;
      fetch_q        <= fetch_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      buf_q          <= buf_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      wr_q           <= wr_d;
      finish_load_q  <= finish_load_d;
      finish_store_q <= finish_store_d;
      finish_fetch_q <= finish_fetch_d;
      data_load_q    <= data_load_d;
      instr_q        <= instr_d;
    end
  end

  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = wr_q & rdy_in;
  assign finish_load     = finish_load_q;
  assign finish_store    = finish_store_q;
  assign finish_fetch    = finish_fetch_q;
  assign data_load       = data_load_q;
  assign instruction_out = instr_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: table-driven loads/stores plus
// hand-written priority, roll_back, IO-full and pause sequences.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, io_buffer_full;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lsb_load, lsb_store, ifetch_req;
  logic [31:0] load_address, store_address, data_store, ifetch_addr;
  logic [5:0]  op_type_load, op_type_store;
  logic        finish_load, finish_store, finish_fetch;
  logic [31:0] data_load, instruction_out;

  memory_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .lsb_load(lsb_load), .load_address(load_address),
    .op_type_load(op_type_load), .finish_load(finish_load), .data_load(data_load),
    .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
    .op_type_store(op_type_store), .finish_store(finish_store), .ifetch_req(ifetch_req),
    .ifetch_addr(ifetch_addr), .finish_fetch(finish_fetch), .instruction_out(instruction_out)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: one-cycle read latency, frozen while rdy_in is low.
  logic [7:0] ram [0:4095];
  always @(posedge clk_in) if (rdy_in) mem_din <= ram[mem_a[11:0]];

  // Bus write log, sampled mid-cycle.
  logic [39:0] wlog [0:255];
  int          wcount = 0;
  always @(negedge clk_in) begin
    if (mem_wr && wcount < 256) begin
      wlog[wcount] = {mem_a, mem_dout};
      wcount++;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] b);
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = addr + i;
      ram[a[11:0]] = b[8*i +: 8];
    end
  endtask

  // Latency = edges from the accepting edge to the edge that raises finish_load.
  task automatic run_load(input logic [5:0] op, input logic [31:0] addr,
                          output logic [31:0] data, output int lat);
    @(negedge clk_in);
    lsb_load = 1'b1; op_type_load = op; load_address = addr;
    lat = -1; data = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (finish_load) begin
        lat = k; data = data_load;
        break;
      end
    end
    lsb_load = 1'b0;
  endtask

  task automatic run_store(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int pause_k, output int lat);
    @(negedge clk_in);
    lsb_store = 1'b1; op_type_store = op; store_address = addr; data_store = data;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (finish_store) begin
        lat = k;
        break;
      end
      if (k == pause_k) rdy_in = 1'b0;
      if (k == pause_k + 2) rdy_in = 1'b1;
    end
    rdy_in = 1'b1;
    lsb_store = 1'b0;
  endtask

  // Flush a load at the edge after negedge rb_k; returns whether finish_load ever rose.
  task automatic rollback_load(input logic [5:0] op, input logic [31:0] addr, output logic seen);
    @(negedge clk_in);
    lsb_load = 1'b1; op_type_load = op; load_address = addr;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (finish_load) seen = 1'b1;
      if (k == 1) begin roll_back = 1'b1; lsb_load = 1'b0; end
      if (k == 2) roll_back = 1'b0;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] bytes_le;
    logic [31:0] exp;
    int          lat;
    string       name;
  } ld_vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          n;
    string       name;
  } st_vec_t;

  ld_vec_t lv [8];
  st_vec_t sv [3];

  initial begin
    logic [31:0] got, prev;
    int          lat, base, t_s, t_l, t_f;
    logic        seen;
    logic [31:0] a;
    logic [31:0] got_data, got_instr;

    lv[0] = '{OP_LW,  32'h0000_0100, 32'h4433_2211, 32'h4433_2211, 5, "lw_0x100"};
    lv[1] = '{OP_LB,  32'h0000_0007, 32'h0000_0080, 32'hFFFF_FF80, 2, "lb_neg"};
    lv[2] = '{OP_LBU, 32'h0000_0007, 32'h0000_0080, 32'h0000_0080, 2, "lbu"};
    lv[3] = '{OP_LHU, 32'h0000_00FF, 32'h0000_80FF, 32'h0000_80FF, 3, "lhu_0xff"};
    lv[4] = '{OP_LH,  32'h0000_00FF, 32'h0000_80FF, 32'hFFFF_80FF, 3, "lh_neg"};
    lv[5] = '{OP_LH,  32'h0000_0010, 32'hAAAA_1234, 32'h0000_1234, 3, "lh_pos"};
    lv[6] = '{OP_LW,  32'hFFFF_FFFE, 32'hD4C3_B2A1, 32'hD4C3_B2A1, 5, "lw_wrap"};
    lv[7] = '{OP_LB,  32'h0000_0020, 32'hAAAA_AA7F, 32'h0000_007F, 2, "lb_pos"};
    sv[0] = '{OP_SW, 32'h0000_0200, 32'hDEAD_BEEF, 4, "sw_0x200"};
    sv[1] = '{OP_SH, 32'h0000_02FF, 32'h1234_ABCD, 2, "sh_0x2ff"};
    sv[2] = '{OP_SB, 32'h0000_0210, 32'h0000_0099, 1, "sb_0x210"};

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b1; io_buffer_full = 1'b0;
    lsb_load = 1'b0; lsb_store = 1'b0; ifetch_req = 1'b0;
    load_address = 32'd0; store_address = 32'd0; data_store = 32'd0; ifetch_addr = 32'd0;
    op_type_load = OP_LW; op_type_store = OP_SW;
    repeat (3) @(negedge clk_in);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_flags", {mem_dout, mem_wr, finish_load, finish_store, finish_fetch}, 12'd0);
    check("rst_data_load", data_load, 32'd0);
    check("rst_instr", instruction_out, 32'd0);
    rst_in = 1'b0; roll_back = 1'b0;

    for (int i = 0; i < 8; i++) begin
      preload(lv[i].addr, lv[i].bytes_le);
      base = wcount;
      run_load(lv[i].op, lv[i].addr, got, lat);
      check({lv[i].name, "_data"}, got, lv[i].exp);
      check({lv[i].name, "_lat"}, lat, lv[i].lat);
      check({lv[i].name, "_nowr"}, wcount - base, 0);
    end

    for (int i = 0; i < 3; i++) begin
      base = wcount;
      run_store(sv[i].op, sv[i].addr, sv[i].data, 99, lat);
      check({sv[i].name, "_lat"}, lat, sv[i].n);
      check({sv[i].name, "_nbytes"}, wcount - base, sv[i].n);
      for (int b = 0; b < sv[i].n; b++) begin
        a = sv[i].addr + b;
        check($sformatf("%s_byte%0d", sv[i].name, b), wlog[base + b], {a, sv[i].data[8*b +: 8]});
      end
    end

    // Priority: all three requesters at once; each finish is 2 + N edges after the previous.
    preload(32'h100, 32'h4433_2211);
    preload(32'h300, 32'h0010_0513);
    @(negedge clk_in);
    lsb_store = 1'b1; op_type_store = OP_SB; store_address = 32'h400; data_store = 32'h77;
    lsb_load = 1'b1; op_type_load = OP_LW; load_address = 32'h100;
    ifetch_req = 1'b1; ifetch_addr = 32'h300;
    t_s = -1; t_l = -1; t_f = -1; got_data = 32'd0; got_instr = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (finish_store) begin t_s = k; lsb_store = 1'b0; end
      if (finish_load)  begin t_l = k; got_data = data_load; lsb_load = 1'b0; end
      if (finish_fetch) begin t_f = k; got_instr = instruction_out; ifetch_req = 1'b0; end
      if (t_f >= 0) break;
    end
    lsb_store = 1'b0; lsb_load = 1'b0; ifetch_req = 1'b0;
    check("prio_store_t", t_s, 1);
    check("prio_load_t", t_l, 8);
    check("prio_fetch_t", t_f, 15);
    check("prio_load_data", got_data, 32'h4433_2211);
    check("prio_instr", got_instr, 32'h0010_0513);

    // roll_back mid-LW, and exactly at the edge an LB would finish.
    prev = data_load;
    rollback_load(OP_LW, 32'h100, seen);
    check("rb_lw_nofinish", seen, 1'b0);
    check("rb_lw_data_held", data_load, prev);
    rollback_load(OP_LB, 32'h7, seen);
    check("rb_lb_nofinish", seen, 1'b0);
    preload(32'h7, 32'h0000_0080);
    run_load(OP_LB, 32'h7, got, lat);
    check("rb_after_lb_data", got, 32'hFFFF_FF80);
    check("rb_after_lb_lat", lat, 2);

    // roll_back during a committed SW is ignored.
    base = wcount;
    @(negedge clk_in);
    lsb_store = 1'b1; op_type_store = OP_SW; store_address = 32'h240; data_store = 32'h0102_0304;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (finish_store) begin lat = k; break; end
      if (k == 1) roll_back = 1'b1;
      if (k == 2) roll_back = 1'b0;
    end
    roll_back = 1'b0; lsb_store = 1'b0;
    check("rb_sw_lat", lat, 4);
    check("rb_sw_nbytes", wcount - base, 4);
    check("rb_sw_last", wlog[base + 3], {32'h243, 8'h01});

    // IO store held off by io_buffer_full.
    base = wcount;
    @(negedge clk_in);
    lsb_store = 1'b1; op_type_store = OP_SB; store_address = 32'h0003_0000; data_store = 32'h5A;
    io_buffer_full = 1'b1; seen = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (finish_store) seen = 1'b1;
    end
    check("io_blocked_nowr", wcount - base, 0);
    check("io_blocked_nofinish", seen, 1'b0);
    io_buffer_full = 1'b0; lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (finish_store) begin lat = k; break; end
    end
    lsb_store = 1'b0;
    check("io_lat", lat, 1);
    check("io_nbytes", wcount - base, 1);
    check("io_byte", wlog[base], {32'h0003_0000, 8'h5A});

    // rdy_in low for two cycles mid-LW: same data, latency + 2.
    preload(32'h500, 32'h0A0B_0C0D);
    @(negedge clk_in);
    lsb_load = 1'b1; op_type_load = OP_LW; load_address = 32'h500;
    lat = -1; got = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (finish_load) begin lat = k; got = data_load; break; end
      if (k == 1) rdy_in = 1'b0;
      if (k == 3) rdy_in = 1'b1;
    end
    rdy_in = 1'b1; lsb_load = 1'b0;
    check("pause_lw_data", got, 32'h0A0B_0C0D);
    check("pause_lw_lat", lat, 7);

    // rdy_in low mid-SW: mem_wr suppressed, still exactly four bytes.
    base = wcount;
    run_store(OP_SW, 32'h260, 32'hCAFE_F00D, 1, lat);
    check("pause_sw_lat", lat, 6);
    check("pause_sw_nbytes", wcount - base, 4);
    check("pause_sw_byte2", wlog[base + 2], {32'h262, 8'hFE});

    repeat (2) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
